// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/round constants, FSM encoding and the round
// transforms (sub_bytes, shift_rows, mix_columns, add_round_key).
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES128_NR = 10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        logic [7:0] b;
        inv = 8'h01;
        sq  = a;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [AES_BLK_W-1:0] sub_bytes(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n sits at [127-8n -: 8], row n%4, column n/4.
    function automatic logic [AES_BLK_W-1:0] shift_rows(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [AES_BLK_W-1:0] add_round_key(input logic [AES_BLK_W-1:0] s,
                                                           input logic [AES_BLK_W-1:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_enc_round_u.sv
// Combinational chain of U AES encryption rounds; the stage whose round index
// equals NR skips MixColumns.
module aes_enc_round_u
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR,
    parameter int U  = 1,
    parameter int RW = $clog2(NR + 1)
) (
    input  logic [AES_BLK_W-1:0]   state_in,
    input  logic [AES_BLK_W*U-1:0] round_keys,
    input  logic [RW-1:0]          start_round,
    output logic [AES_BLK_W-1:0]   state_out
);

    logic [U:0][AES_BLK_W-1:0] chain;

    assign chain[0] = state_in;

    for (genvar k = 0; k < U; k++) begin : g_stage
        logic                 is_final;
        logic [AES_BLK_W-1:0] shifted;
        logic [AES_BLK_W-1:0] mixed;

        assign is_final    = (int'(start_round) + k == NR);
        assign shifted     = shift_rows(sub_bytes(chain[k]));
        assign mixed       = is_final ? shifted : mix_columns(shifted);
        assign chain[k+1]  = add_round_key(mixed, round_keys[AES_BLK_W*k +: AES_BLK_W]);
    end

    assign state_out = chain[U];

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 ECB encryptor, U rounds per clock, valid/ready on both sides.
// Optional AES_ENC_BLKCNT_EN adds a 32-bit delivered-block counter port.
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR,
    parameter int U  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AES_BLK_W*(NR+1)-1:0] rk_flat,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [AES_BLK_W-1:0]        plain_text,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [AES_BLK_W-1:0]        cipher_text
`ifdef AES_ENC_BLKCNT_EN
    ,
    output logic [31:0]                 blk_count
`endif
);

    localparam int RW = $clog2(NR + 1);

    if (NR % U != 0) begin : g_bad_u
        $error("aes128_enc_iter: NR must be a multiple of U");
    end

    fsm_t                   state, next_state;
    logic [RW-1:0]          round_cnt;
    logic [RW-1:0]          start_round;
    logic [AES_BLK_W-1:0]   state_reg;
    logic [AES_BLK_W-1:0]   round_out;
    logic [AES_BLK_W*U-1:0] round_keys;
    logic                   load;
    logic                   ready;

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (int'(round_cnt) + U == NR) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                ready     = out_ready;
                // Delivery and a new accept share the edge, so there is no bubble.
                if (out_ready) begin
                    if (in_valid) begin
                        load       = 1'b1;
                        next_state = BUSY;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready    = ready & reset;
    assign cipher_text = out_valid ? state_reg : '0;
    assign start_round = round_cnt + RW'(1);

    // Keys for rounds round_cnt+1 .. round_cnt+U; rk_flat is not latched.
    always_comb begin
        round_keys = '0;
        for (int k = 0; k < U; k++)
            for (int r = 1; r <= NR; r++)
                if (int'(round_cnt) + 1 + k == r)
                    round_keys[AES_BLK_W*k +: AES_BLK_W] = rk_flat[AES_BLK_W*r +: AES_BLK_W];
    end

    aes_enc_round_u #(.NR(NR), .U(U), .RW(RW)) u_rounds (
        .state_in    (state_reg),
        .round_keys  (round_keys),
        .start_round (start_round),
        .state_out   (round_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            state_reg <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                state_reg <= plain_text ^ rk_flat[AES_BLK_W-1:0];
                round_cnt <= '0;
            end else if (state == BUSY) begin
                state_reg <= round_out;
                round_cnt <= round_cnt + RW'(U);
            end
        end
    end

`ifdef AES_ENC_BLKCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      blk_count <= '0;
        else if (out_valid && out_ready) blk_count <= blk_count + 32'd1;
    end
`endif

endmodule
